pcbfpga_cfg_cluster: RTL and testbench

- Cluster of N K-input LUT cells, each with an optional output register.
- The cell configuration (LUT INIT, register bypass, register reset value) is loaded at run time through a serial configuration port instead of being fixed by parameters.
- Configuration is double-buffered: a shadow register fills while the active configuration keeps driving logic, then all cells switch atomically.
- It is the next-generation logic tile for the PCB FPGA fabric, replacing fixed-INIT LUT plus flip-flop pairs.

---
 rtl/pcbfpga_cfg_cluster.sv | 123 ++++++++++++
 tb/tb_pcbfpga_cfg_cluster.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/pcbfpga_cfg_cluster.sv
// N-cell K-input LUT cluster with a double-buffered serial configuration port.
// Define PCBFPGA_CFG_READBACK_EN to shift the previous active configuration out on CFG_DO.
module pcbfpga_cfg_cluster #(
    parameter int K = 4,
    parameter int N = 4
) (
    input  logic           CLK,
    input  logic           RST,
    input  logic           CFG_START,
    input  logic           CFG_VALID,
    input  logic           CFG_DI,
    output logic           CFG_DO,
    output logic           CFG_BUSY,
    output logic           CFG_DONE,
    input  logic [N*K-1:0] I,
    input  logic [N-1:0]   EN,
    input  logic [N-1:0]   SR,
    output logic [N-1:0]   F
);
    localparam int LW      = 2**K;
    localparam int CB      = LW + 2;
    localparam int CFG_LEN = N * CB;
    localparam int CW      = $clog2(CFG_LEN + 1);

    typedef enum logic [1:0] {IDLE, LOAD, COMMIT} state_t;

    state_t               state_reg, state_next;
    logic [CW-1:0]        count_reg, count_next;
    logic [CFG_LEN-1:0]   shadow_reg, shadow_next;
    logic [CFG_LEN-1:0]   active_reg;
    logic                 done_reg;
    logic                 commit;

    assign commit = (state_reg == COMMIT);

    always_comb begin
        state_next  = state_reg;
        count_next  = count_reg;
        shadow_next = shadow_reg;
        case (state_reg)
            IDLE: begin
                if (CFG_START) begin
                    state_next = LOAD;
                    count_next = '0;
`ifdef PCBFPGA_CFG_READBACK_EN
                    shadow_next = active_reg;
`endif
                end
            end
            LOAD: begin
                // A restart drops any bit presented in the same cycle.
                if (CFG_START) begin
                    count_next = '0;
`ifdef PCBFPGA_CFG_READBACK_EN
                    shadow_next = active_reg;
`endif
                end else if (CFG_VALID) begin
                    shadow_next = {shadow_reg[CFG_LEN-2:0], CFG_DI};
                    count_next  = count_reg + CW'(1);
                    if (count_reg == CW'(CFG_LEN - 1))
                        state_next = COMMIT;
                end
            end
            COMMIT:  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_reg  <= IDLE;
            count_reg  <= '0;
            shadow_reg <= '0;
            active_reg <= '0;
            done_reg   <= 1'b0;
        end else begin
            state_reg  <= state_next;
            count_reg  <= count_next;
            shadow_reg <= shadow_next;
            done_reg   <= commit;
            if (commit)
                active_reg <= shadow_reg;
        end
    end

    assign CFG_BUSY = (state_reg != IDLE);
    assign CFG_DONE = done_reg;
`ifdef PCBFPGA_CFG_READBACK_EN
    assign CFG_DO = shadow_reg[CFG_LEN-1];
`else
    assign CFG_DO = 1'b0;
`endif

    for (genvar gi = 0; gi < N; gi++) begin : g_cell
        logic [LW-1:0] init;
        logic          reg_mode;
        logic          rval;
        logic          lut;
        logic          q_reg;

        assign init     = active_reg[gi*CB +: LW];
        assign reg_mode = active_reg[gi*CB + LW];
        assign rval     = active_reg[gi*CB + LW + 1];
        assign lut      = init[I[gi*K +: K]];

        // The commit edge preloads Q with the incoming RVAL regardless of SR/EN.
        always_ff @(posedge CLK) begin
            if (RST)
                q_reg <= 1'b0;
            else if (commit)
                q_reg <= shadow_reg[gi*CB + LW + 1];
            else if (reg_mode) begin
                if (SR[gi])
                    q_reg <= rval;
                else if (EN[gi])
                    q_reg <= lut;
            end
        end

        assign F[gi] = reg_mode ? q_reg : lut;
    end

endmodule

// File: tb/tb_pcbfpga_cfg_cluster.sv
// Randomized bench for pcbfpga_cfg_cluster (K=4, N=2) against a cell-level reference model.
// Readback expectations follow PCBFPGA_CFG_READBACK_EN when it is defined.
module tb_pcbfpga_cfg_cluster;
    localparam int K   = 4;
    localparam int N   = 2;
    localparam int LW  = 16;
    localparam int CB  = LW + 2;
    localparam int LEN = N * CB;

    typedef struct packed {
        logic [N-1:0][LW-1:0] init;
        logic [N-1:0]         regb;
        logic [N-1:0]         rval;
    } cfg_t;
    typedef bit bitq_t[$];

    logic           CLK = 1'b0;
    logic           RST = 1'b1;
    logic           CFG_START = 1'b0;
    logic           CFG_VALID = 1'b0;
    logic           CFG_DI = 1'b0;
    logic           CFG_DO, CFG_BUSY, CFG_DONE;
    logic [N*K-1:0] I = '0;
    logic [N-1:0]   EN = '0;
    logic [N-1:0]   SR = '0;
    logic [N-1:0]   F;

    int n_cmp = 0;
    int n_bad = 0;
    int done_seen = 0;

    // Reference model: active config as cell fields, shadow as an MSB-first bit list.
    cfg_t       m_act;
    logic [N-1:0] m_q;
    bit         m_sh[$];
    int         m_phase;   // 0 idle, 1 loading, 2 commit pending
    int         m_got;
    bit         m_done;

    pcbfpga_cfg_cluster #(.K(K), .N(N)) dut (
        .CLK(CLK), .RST(RST), .CFG_START(CFG_START), .CFG_VALID(CFG_VALID),
        .CFG_DI(CFG_DI), .CFG_DO(CFG_DO), .CFG_BUSY(CFG_BUSY), .CFG_DONE(CFG_DONE),
        .I(I), .EN(EN), .SR(SR), .F(F)
    );

    always #5 CLK = ~CLK;

    function automatic bitq_t stream_of(input cfg_t c);
        bitq_t s;
        for (int n = N - 1; n >= 0; n--) begin
            s.push_back(c.rval[n]);
            s.push_back(c.regb[n]);
            for (int b = LW - 1; b >= 0; b--) s.push_back(c.init[n][b]);
        end
        return s;
    endfunction

    function automatic logic [N-1:0] model_lut(input logic [N*K-1:0] iv);
        logic [N-1:0] l;
        for (int n = 0; n < N; n++) l[n] = m_act.init[n][iv[n*K +: K]];
        return l;
    endfunction

    function automatic logic [N-1:0] model_f();
        logic [N-1:0] l, f;
        l = model_lut(I);
        for (int n = 0; n < N; n++) f[n] = m_act.regb[n] ? m_q[n] : l[n];
        return f;
    endfunction

    function automatic logic model_do();
`ifdef PCBFPGA_CFG_READBACK_EN
        return m_sh[0];
`else
        return 1'b0;
`endif
    endfunction

    task automatic model_reset();
        m_act = '0; m_q = '0; m_phase = 0; m_got = 0; m_done = 0;
        m_sh.delete();
        for (int j = 0; j < LEN; j++) m_sh.push_back(1'b0);
    endtask

    task automatic model_edge(input bit rst, input bit start, input bit valid, input bit di);
        logic [N-1:0] l;
        if (rst) begin
            model_reset();
            return;
        end
        l = model_lut(I);
        m_done = 0;
        for (int n = 0; n < N; n++)
            if (m_act.regb[n]) begin
                if (SR[n]) m_q[n] = m_act.rval[n];
                else if (EN[n]) m_q[n] = l[n];
            end
        if (m_phase == 2) begin
            for (int n = 0; n < N; n++) begin
                for (int b = 0; b < LW; b++) m_act.init[n][b] = m_sh[LEN-1-(n*CB+b)];
                m_act.regb[n] = m_sh[LEN-1-(n*CB+LW)];
                m_act.rval[n] = m_sh[LEN-1-(n*CB+LW+1)];
                m_q[n] = m_act.rval[n];
            end
            m_done = 1;
            m_phase = 0;
        end else if (start) begin
            m_phase = 1;
            m_got = 0;
`ifdef PCBFPGA_CFG_READBACK_EN
            m_sh = stream_of(m_act);
`endif
        end else if (m_phase == 1 && valid) begin
            void'(m_sh.pop_front());
            m_sh.push_back(di);
            m_got++;
            if (m_got == LEN) m_phase = 2;
        end
    endtask

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [N*K-1:0] ri();
        return (N*K)'($urandom);
    endfunction
    function automatic logic [N-1:0] ren();
        return N'($urandom);
    endfunction
    function automatic logic [N-1:0] rsr();
        logic [N-1:0] s;
        for (int n = 0; n < N; n++) s[n] = ($urandom_range(0, 3) == 0);
        return s;
    endfunction

    task automatic step(input bit rst, input bit start, input bit valid, input bit di,
                        input logic [N*K-1:0] iv, input logic [N-1:0] en,
                        input logic [N-1:0] sr, input string tag);
        RST = rst; CFG_START = start; CFG_VALID = valid; CFG_DI = di;
        I = iv; EN = en; SR = sr;
        @(posedge CLK);
        model_edge(rst, start, valid, di);
        #1;
        if (CFG_DONE === 1'b1) done_seen++;
        check({tag, ".F"}, 16'(F), 16'(model_f()));
        check({tag, ".busy"}, 16'(CFG_BUSY), 16'(m_phase != 0));
        check({tag, ".done"}, 16'(CFG_DONE), 16'(m_done));
        check({tag, ".do"}, 16'(CFG_DO), 16'(model_do()));
        I = ri();
        #1;
        check({tag, ".Fcomb"}, 16'(F), 16'(model_f()));
    endtask

    task automatic rstep(input string tag);
        step(0, 0, 1'($urandom), 1'($urandom), ri(), ren(), rsr(), tag);
    endtask

    task automatic send(input bitq_t s, input int upto, input string tag);
        for (int j = 0; j < upto; j++) begin
            while ($urandom_range(0, 2) == 0)
                step(0, 0, 0, 1'($urandom), ri(), ren(), rsr(), tag);
            step(0, 0, 1, s[j], ri(), ren(), rsr(), tag);
        end
    endtask

    task automatic load(input cfg_t c, input string tag);
        step(0, 1, 0, 0, ri(), ren(), rsr(), tag);
        send(stream_of(c), LEN, tag);
        step(0, 0, 0, 0, ri(), ren(), rsr(), tag);
    endtask

    function automatic cfg_t rcfg();
        cfg_t c;
        for (int n = 0; n < N; n++) c.init[n] = LW'($urandom);
        c.regb = ren();
        c.rval = ren();
        return c;
    endfunction

    initial begin
        cfg_t a, b, c;
        int d0;
        logic [N*K-1:0] iv;
        model_reset();

        // 1. reset with arbitrary inputs, then idle traffic with stray CFG_VALID
        step(1, 1'($urandom), 1'($urandom), 1'($urandom), ri(), ren(), ren(), "rst");
        step(1, 1'($urandom), 1'($urandom), 1'($urandom), ri(), ren(), ren(), "rst");
        check("rst_F", 16'(F), 16'h0);
        for (int j = 0; j < 8; j++) rstep("idle");

        // 2. directed load
        a = '0;
        a.init[1] = 16'h6996; a.regb[1] = 1'b1; a.rval[1] = 1'b1;
        a.init[0] = 16'h8000; a.regb[0] = 1'b0;
        step(0, 1, 0, 0, ri(), ren(), rsr(), "loadA");
        send(stream_of(a), LEN, "loadA");
        check("loadA_pending", 16'(CFG_BUSY), 16'h1);
        d0 = done_seen;
        step(0, 0, 0, 0, ri(), '0, '0, "loadA_commit");
        check("loadA_done_next", 16'(done_seen - d0), 16'h1);
        check("loadA_F1_rval", 16'(F[1]), 16'h1);
        for (int v = 0; v < 256; v++) begin
            iv = 8'(v);
            I = iv; #1;
            check("and4", 16'(F[0]), 16'(iv[3:0] == 4'hF));
        end
        for (int j = 0; j < 20; j++) rstep("runA");

        // 3. abort after 20 bits, then full second stream
        b = rcfg(); c = rcfg();
        d0 = done_seen;
        step(0, 1, 0, 0, ri(), ren(), rsr(), "abort");
        send(stream_of(b), 20, "abort");
        step(0, 1, 1, 1'($urandom), ri(), ren(), rsr(), "abort_restart");
        send(stream_of(c), LEN, "abort2");
        step(0, 0, 0, 0, ri(), ren(), rsr(), "abort_commit");
        for (int j = 0; j < 10; j++) rstep("runC");
        check("abort_one_done", 16'(done_seen - d0), 16'h1);

        // 4. SR priority over EN, then hold
        a = rcfg();
        a.init[0] = 16'hFFFF; a.regb[0] = 1'b1; a.rval[0] = 1'b0;
        load(a, "prio_load");
        step(0, 0, 0, 0, ri(), 2'b01, 2'b00, "prio_en");
        check("prio_en_q", 16'(F[0]), 16'h1);
        step(0, 0, 0, 0, ri(), 2'b01, 2'b01, "prio_sr");
        check("prio_sr_q", 16'(F[0]), 16'h0);
        step(0, 0, 0, 0, ri(), 2'b01, 2'b00, "prio_en2");
        for (int j = 0; j < 3; j++) step(0, 0, 0, 0, ri(), 2'b00, 2'b00, "prio_hold");
        check("prio_hold_q", 16'(F[0]), 16'h1);

        // 5. reset mid-load, then orphan bits must not commit
        step(0, 1, 0, 0, ri(), ren(), rsr(), "rstload");
        send(stream_of(rcfg()), 10, "rstload");
        step(1, 0, 1, 1'($urandom), ri(), ren(), rsr(), "rstload_rst");
        check("rstload_F", 16'(F), 16'h0);
        d0 = done_seen;
        for (int j = 0; j < 30; j++) step(0, 0, 1, 1'($urandom), ri(), ren(), rsr(), "orphan");
        check("orphan_no_done", 16'(done_seen - d0), 16'h0);

        // 6. readback: load A, then stream B while A shifts out
        a = rcfg(); b = rcfg();
        load(a, "rbA");
        load(b, "rbB");
        for (int j = 0; j < 10; j++) rstep("runB");

        // random reloads
        for (int r = 0; r < 4; r++) begin
            load(rcfg(), "rand");
            for (int j = 0; j < 8; j++) rstep("rand_run");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end
endmodule
